// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB bridge: FSM states, slave-select codes, default timeout.
package apb_master_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RDCAP  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_SLAVE1 = 2'b00;
    localparam logic [1:0] SEL_SLAVE2 = 2'b01;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/apb_addr_decode.sv
// Maps the two slave-select address bits to a one-hot PSEL vector plus a decode-error flag.
// Purely combinational; no latency, no backpressure.
module apb_addr_decode
    import apb_master_pkg::*;
(
    input  logic [1:0] slave_bits,
    output logic [1:0] sel,
    output logic       err
);

    always_comb begin
        sel = 2'b00;
        err = 1'b0;
        case (slave_bits)
            SEL_SLAVE1: sel = 2'b01;
            SEL_SLAVE2: sel = 2'b10;
            default:    err = 1'b1;
        endcase
    end

endmodule

// File: rtl/apb_master.sv
// Valid/ready request port to two-slave APB bridge; write 3 cycles, read 4 cycles plus wait states, decode error 1 cycle.
// req_ready only in IDLE, so one request is in flight at a time; stuck slaves are aborted after TIMEOUT access cycles.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [7:0]        PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY1,
    input  logic              PREADY2
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              wr_q;
    logic [5:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        sel_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0] dec_sel;
    logic       dec_err;
    logic       pready_sel;
    logic       apb_active;

    apb_addr_decode u_dec (
        .slave_bits (req_addr[7:6]),
        .sel        (dec_sel),
        .err        (dec_err)
    );

    // Only the selected slave's PREADY may end the access phase.
    assign pready_sel = (sel_q[0] & PREADY1) | (sel_q[1] & PREADY2);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        apb_active = 1'b0;
        PENABLE    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = dec_err ? RESP : SETUP;
                end
            end
            SETUP: begin
                apb_active = 1'b1;
                state_d    = ACCESS;
            end
            ACCESS: begin
                apb_active = 1'b1;
                PENABLE    = 1'b1;
                if (pready_sel) begin
                    state_d = wr_q ? RESP : RDCAP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                end
            end
            RDCAP: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_q    <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            sel_q   <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        off_q   <= req_addr[5:0];
                        wdata_q <= req_wdata;
                        sel_q   <= dec_sel;
                        err_q   <= dec_err;
                        rdata_q <= '0;
                    end
                end
                SETUP: cnt_q <= '0;
                ACCESS: begin
                    // Counter saturates at the last value; the FSM leaves ACCESS on that same edge.
                    if (!pready_sel) begin
                        if (cnt_q == CNT_LAST) begin
                            err_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                // Slaves register read data at the access edge, so it is valid one cycle later.
                RDCAP: rdata_q <= sel_q[1] ? PRDATA2 : PRDATA1;
                default: ;
            endcase
        end
    end

    assign PSEL1     = apb_active & sel_q[0];
    assign PSEL2     = apb_active & sel_q[1];
    assign PWRITE    = apb_active & wr_q;
    assign PADDR     = apb_active ? {2'b00, off_q} : 8'h00;
    assign PWDATA    = apb_active ? wdata_q : '0;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

endmodule
